usb_stream_packetizer: RTL and testbench



---
 rtl/usb_pkt_pkg.sv | 41 ++++
 rtl/usb_stream_packetizer.sv | 134 +++++++++++++
 tb/tb_usb_stream_packetizer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkt_pkg.sv
// Shared definitions for the USB stream packetizer: header layout, FSM states
// and header builders.
package usb_pkt_pkg;

  localparam logic [7:0] PKT_MAGIC = 8'hA5;

  // Header word 0: {magic, stream id, sequence}
  localparam int HDR0_MAGIC_LSB = 24;
  localparam int HDR0_ID_LSB    = 16;
  localparam int HDR0_SEQ_LSB   = 0;
  // Header word 1: {drop count, payload length}
  localparam int HDR1_DROP_LSB  = 16;
  localparam int HDR1_LEN_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_PAD,
    ST_PUSH
  } pkt_state_e;

  function automatic logic [31:0] build_hdr0(input logic [7:0] id, input logic [15:0] seq);
    logic [31:0] h;
    h = '0;
    h[HDR0_MAGIC_LSB +: 8] = PKT_MAGIC;
    h[HDR0_ID_LSB    +: 8] = id;
    h[HDR0_SEQ_LSB   +: 16] = seq;
    return h;
  endfunction

  function automatic logic [31:0] build_hdr1(input logic [15:0] drops, input logic [15:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR1_DROP_LSB +: 16] = drops;
    h[HDR1_LEN_LSB  +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/usb_stream_packetizer.sv
// Frames a 32-bit sample stream into fixed-size packets (2 header words +
// PAYLOAD_WORDS payload words + push) for one FT601 write-buffer channel.
module usb_stream_packetizer
  import usb_pkt_pkg::*;
#(
  parameter int         PAYLOAD_WORDS = 254,
  parameter logic [7:0] STREAM_ID     = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic        wr_en,
  output logic        wr_push,
  input  logic        wr_almost_full,
  input  logic        wr_has_packet_space,
  output logic [15:0] seq_num,
  output logic [15:0] drop_count
);

  localparam int              CW   = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CW-1:0]   LAST = CW'(PAYLOAD_WORDS);
  localparam logic [15:0]     LEN  = 16'(PAYLOAD_WORDS);

  pkt_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [3:0]    wr_be_q, wr_be_d;
  logic          wr_en_q, wr_en_d;
  logic          wr_push_q, wr_push_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   drop_q, drop_d;
  logic          drop_now;

  assign cnt_inc    = cnt_q + 1'b1;
  assign wr_data    = wr_data_q;
  assign wr_be      = wr_be_q;
  assign wr_en      = wr_en_q;
  assign wr_push    = wr_push_q;
  assign seq_num    = seq_q;
  assign drop_count = drop_q;

  // Input handshake: only payload words are taken, and only with room downstream
  always_comb begin
    in_ready = (state_q == ST_PAYLOAD) && enable && !wr_almost_full;
    drop_now = in_valid && !in_ready;
  end

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    wr_data_d = '0;
    wr_be_d   = '0;
    wr_en_d   = 1'b0;
    wr_push_d = 1'b0;
    drop_d    = (drop_now && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    case (state_q)
      ST_IDLE: begin
        // Space for a whole packet is checked once here; headers never stall
        if (enable && wr_has_packet_space) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        wr_data_d = build_hdr0(STREAM_ID, seq_q);
        wr_be_d   = 4'hF;
        wr_en_d   = 1'b1;
        cnt_d     = '0;
        state_d   = ST_HDR1;
      end
      ST_HDR1: begin
        // Drops are reported here; one arriving this very cycle is kept for next time
        wr_data_d = build_hdr1(drop_q, LEN);
        wr_be_d   = 4'hF;
        wr_en_d   = 1'b1;
        drop_d    = {15'd0, drop_now};
        state_d   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (in_valid && in_ready) begin
          wr_data_d = in_data;
          wr_be_d   = 4'hF;
          wr_en_d   = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc == LAST) state_d = ST_PUSH;
        end else if (!enable) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        // Pad words carry no enabled bytes but still fill the fixed packet size
        if (!wr_almost_full) begin
          wr_en_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == LAST) state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        wr_push_d = 1'b1;
        seq_d     = seq_q + 16'd1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial packet without a push
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_push_q <= 1'b0;
      seq_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      wr_en_q   <= wr_en_d;
      wr_push_q <= wr_push_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_usb_stream_packetizer.sv
// Bench for usb_stream_packetizer: directed scenarios plus random traffic,
// checked against a packet-level reference model.
module tb_usb_stream_packetizer;

  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_en;
  logic        wr_push;
  logic        wr_almost_full = 1'b0;
  logic        wr_has_packet_space = 1'b0;
  logic [15:0] seq_num;
  logic [15:0] drop_count;

  usb_stream_packetizer #(.PAYLOAD_WORDS(PW), .STREAM_ID(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_data(wr_data), .wr_be(wr_be), .wr_en(wr_en), .wr_push(wr_push),
    .wr_almost_full(wr_almost_full), .wr_has_packet_space(wr_has_packet_space),
    .seq_num(seq_num), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packets seen as header pair + queue of expected body beats
  logic [35:0] accq[$];  // {be, data}
  int  tally;            // drops accumulated through the previous cycle
  bit  pend;             // drop occurring in the current cycle
  int  beat;             // 0: waiting for hdr0, 1: expect hdr1, >=2: body
  int  body_q;           // body beats predicted for the current packet
  bit  in_body, pad, idle, push_due;
  int  start_cd;
  int  exp_seq;
  logic [31:0] ramp;

  task automatic model_init();
    accq.delete();
    tally = 0; pend = 0; beat = 0; body_q = 0;
    in_body = 0; pad = 0; idle = 1; push_due = 0; start_cd = 0; exp_seq = 0;
  endtask

  // Called mid-cycle once inputs are settled: predicts this cycle's effects
  task automatic model_step();
    bit exp_ready;
    exp_ready = in_body && !pad && enable && !wr_almost_full;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    pend = in_valid && !exp_ready;
    if (in_body) begin
      if (!pad) begin
        if (in_valid && exp_ready) begin
          accq.push_back({4'hF, in_data});
          body_q++;
          ramp = ramp + 1;
        end else if (!enable) begin
          pad = 1;
        end
      end else if (!wr_almost_full) begin
        accq.push_back(36'h0);
        body_q++;
      end
      if (body_q == PW) in_body = 0;
    end
    if (idle && enable && wr_has_packet_space) begin
      start_cd = 2;
      idle = 0;
    end
  endtask

  // Called at the falling edge: compares registered outputs with the model
  task automatic observe();
    bit hdr_now, exp_en, hdr1_seen;
    logic [35:0] e;
    int s;
    hdr_now = 0; hdr1_seen = 0;
    if (start_cd > 0) begin
      start_cd--;
      if (start_cd == 0) hdr_now = 1;
    end
    chk("wr_push", 32'(wr_push), 32'(push_due));
    if (push_due) begin
      push_due = 0;
      exp_seq = (exp_seq + 1) % 65536;
      idle = 1;
    end
    exp_en = hdr_now || beat == 1 || (beat >= 2 && accq.size() > 0);
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    if (wr_en && exp_en) begin
      if (hdr_now) begin
        chk("hdr0", wr_data, {8'hA5, 8'h00, 16'(exp_seq)});
        chk("hdr0_be", 32'(wr_be), 32'hF);
        beat = 1;
      end else if (beat == 1) begin
        chk("hdr1", wr_data, {16'(tally), 16'(PW)});
        chk("hdr1_be", 32'(wr_be), 32'hF);
        hdr1_seen = 1;
        beat = 2; in_body = 1; pad = 0; body_q = 0;
      end else begin
        e = accq.pop_front();
        chk("body", wr_data, e[31:0]);
        chk("body_be", 32'(wr_be), 32'(e[35:32]));
        beat++;
        if (beat == PW + 2) begin
          push_due = 1;
          beat = 0;
        end
      end
    end
    if (hdr1_seen) tally = int'(pend);
    else begin
      s = tally + int'(pend);
      tally = (s > 65535) ? 65535 : s;
    end
    chk("drop_count", 32'(drop_count), 32'(tally));
    chk("seq_num", 32'(seq_num), 32'(exp_seq));
  endtask

  task automatic cycle(input bit en, input bit val, input bit af, input bit sp, input logic [31:0] d);
    enable = en; in_valid = val; wr_almost_full = af; wr_has_packet_space = sp; in_data = d;
    #1;
    model_step();
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_wr_be", 32'(wr_be), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_push", 32'(wr_push), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_seq", 32'(seq_num), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    model_init();
    reset_n = 1'b1;
  endtask

  initial begin
    model_init();
    ramp = 0;
    repeat (3) @(posedge clk);
    do_reset();

    // Continuous ramp, full space: back-to-back packets
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 1, ramp);

    // Input stall mid-payload
    for (int i = 0; i < 30; i++) cycle(1, !(i >= 8 && i < 13), 0, 1, ramp);

    // Drops while idle without packet space, then reported in hdr1
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0, ramp);
    chk("drop7", 32'(drop_count), 32'd7);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, ramp);
    chk("drop_clr", 32'(drop_count), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 1, ramp);

    // Enable falls after two payload words: padding, push, then stay idle
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, ramp);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, ramp);

    // Almost-full for three payload cycles
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 1, (i >= 5 && i < 8), 1, ramp);

    // Counter extremes: saturate drops and wrap the sequence number
    do_reset();
    force dut.drop_q = 16'hFFF0;
    force dut.seq_q  = 16'hFFFF;
    tally = 16'hFFF0;
    exp_seq = 16'hFFFF;
    cycle(0, 0, 0, 0, ramp);
    release dut.drop_q;
    release dut.seq_q;
    for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0, ramp);
    chk("drop_sat", 32'(drop_count), 32'hFFFF);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 1, ramp);
    cycle(0, 0, 0, 1, ramp);
    chk("seq_wrap", 32'(seq_num), 32'h0);

    // Reset in the middle of a payload: nothing committed
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, ramp);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, ramp);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 16) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
            ($urandom % 4) != 0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
